// File: rtl/dcache_controller_if.sv
// CPU-side load/store path and block-wide memory path of the data cache.
// CPU holds READ/WRITE/ADDRESS/WRITEDATA while BUSYWAIT=1; an access completes on the first edge with BUSYWAIT=0.
interface dcache_controller_if;
   logic        READ;
   logic        WRITE;
   logic [7:0]  ADDRESS;
   logic [7:0]  WRITEDATA;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   modport slave (
      input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );

   modport master (
      output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache: 8 lines x 4 bytes, hits served in the same cycle,
// misses handled by a WRITEBACK/FETCH/UPDATE sequence against block-wide memory.
module dcache_controller (
   input  logic                CLK,
   input  logic                RESET,
   dcache_controller_if.slave  bus,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      UPDATE    = 2'd3
   } state_t;

   state_t      state, next_state;
   logic [7:0]  valid;
   logic [7:0]  dirty;
   logic [2:0]  tags [8];
   logic [31:0] data [8];
   logic [31:0] fill;

   logic [2:0]  idx;
   logic [2:0]  tag_in;
   logic [4:0]  bsel;
   logic        hit;
   logic        access;

   logic        byte_wr;
   logic        line_wr;
   logic        fill_en;
   logic [7:0]  readdata;
   logic        busywait;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;

   assign idx    = bus.ADDRESS[4:2];
   assign tag_in = bus.ADDRESS[7:5];
   assign bsel   = {bus.ADDRESS[1:0], 3'b000};
   assign hit    = valid[idx] && (tags[idx] == tag_in);
   assign access = bus.READ || bus.WRITE;

   always_comb begin
      next_state    = state;
      byte_wr       = 1'b0;
      line_wr       = 1'b0;
      fill_en       = 1'b0;
      readdata      = 8'h00;
      busywait      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = 6'h00;
      mem_writedata = 32'h0;
      case (state)
         IDLE: begin
            readdata = data[idx][bsel +: 8];
            if (access && !hit) begin
               busywait   = 1'b1;
               next_state = dirty[idx] ? WRITEBACK : FETCH;
            end else if (bus.WRITE && hit) begin
               byte_wr = 1'b1;
            end
         end
         WRITEBACK: begin
            busywait      = 1'b1;
            mem_write     = 1'b1;
            mem_address   = {tags[idx], idx};
            mem_writedata = data[idx];
            if (!bus.MEM_BUSYWAIT) next_state = FETCH;
         end
         FETCH: begin
            busywait    = 1'b1;
            mem_read    = 1'b1;
            mem_address = {tag_in, idx};
            if (!bus.MEM_BUSYWAIT) begin
               fill_en    = 1'b1;
               next_state = UPDATE;
            end
         end
         UPDATE: begin
            busywait   = 1'b1;
            line_wr    = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      // Reset is asynchronous: outputs and line updates are squashed the moment it asserts.
      if (!RESET) begin
         next_state    = IDLE;
         byte_wr       = 1'b0;
         line_wr       = 1'b0;
         fill_en       = 1'b0;
         readdata      = 8'h00;
         busywait      = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         mem_address   = 6'h00;
         mem_writedata = 32'h0;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
         valid <= 8'h00;
         dirty <= 8'h00;
      end else begin
         state <= next_state;
         if (line_wr) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end else if (byte_wr) begin
            dirty[idx] <= 1'b1;
         end
      end
   end

   // Tag, data and fill storage carry no reset; valid bits guard their contents.
   always_ff @(posedge CLK) begin
      if (fill_en) fill <= bus.MEM_READDATA;
      if (line_wr) begin
         data[idx] <= fill;
         tags[idx] <= tag_in;
      end else if (byte_wr) begin
         data[idx][bsel +: 8] <= bus.WRITEDATA;
      end
   end

   assign bus.READDATA      = readdata;
   assign bus.BUSYWAIT      = busywait;
   assign bus.MEM_READ      = mem_read;
   assign bus.MEM_WRITE     = mem_write;
   assign bus.MEM_ADDRESS   = mem_address;
   assign bus.MEM_WRITEDATA = mem_writedata;
   assign dbg_state         = state;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency block memory model and
// scoreboards for CPU access completions and memory transfers.
module tb_dcache_controller;

   localparam int LAT = 5;

   logic        CLK;
   logic        RESET;
   logic [1:0]  dbg_state;

   dcache_controller_if bus ();

   dcache_controller dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   // CPU record: {is_read, readdata[7:0], stall_cycles[7:0]}
   logic [16:0] exp_q[$];
   // Memory record: {is_write, block_addr[5:0], writedata[31:0]}
   logic [38:0] exp_mem_q[$];

   logic [31:0] mem [64];
   int          mem_cnt;
   int          stall_cnt;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Memory model: busy for LAT-1 cycles of a request, then low for the completing cycle.
   assign bus.MEM_BUSYWAIT = (bus.MEM_READ || bus.MEM_WRITE) && (mem_cnt != LAT - 1);
   assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];

   always @(posedge CLK) begin
      if (!RESET || !(bus.MEM_READ || bus.MEM_WRITE)) begin
         mem_cnt <= 0;
      end else if (mem_cnt == LAT - 1) begin
         if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
         mem_cnt <= 0;
      end else begin
         mem_cnt <= mem_cnt + 1;
      end
   end

   // Monitors
   always @(negedge CLK) begin
      logic [16:0] e;
      logic [38:0] m;
      if (!RESET) begin
         stall_cnt = 0;
      end else begin
         check("mem_rd_wr_exclusive", {62'd0, bus.MEM_READ, bus.MEM_WRITE} != 64'd3, 64'd1);
         if (!bus.MEM_READ && !bus.MEM_WRITE)
            check("mem_idle_zero", {26'd0, bus.MEM_ADDRESS, bus.MEM_WRITEDATA}, 64'd0);
         if (bus.READ || bus.WRITE) begin
            if (bus.BUSYWAIT) begin
               stall_cnt++;
            end else if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL cpu_unexpected_completion addr=%0h", bus.ADDRESS);
            end else begin
               e = exp_q.pop_front();
               check("cpu_stall_cycles", 64'(stall_cnt), {56'd0, e[7:0]});
               if (e[16]) check("cpu_readdata", {56'd0, bus.READDATA}, {56'd0, e[15:8]});
               stall_cnt = 0;
            end
         end
         if ((bus.MEM_READ || bus.MEM_WRITE) && !bus.MEM_BUSYWAIT) begin
            if (exp_mem_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL mem_unexpected_transfer actual=%0h", bus.MEM_ADDRESS);
            end else begin
               m = exp_mem_q.pop_front();
               check("mem_transfer", {25'd0, bus.MEM_WRITE, bus.MEM_ADDRESS,
                     (bus.MEM_WRITE ? bus.MEM_WRITEDATA : 32'h0)}, {25'd0, m});
            end
         end
      end
   end

   task automatic push_cpu(input logic is_read, input logic [7:0] rd, input logic [7:0] stall);
      exp_q.push_back({is_read, rd, stall});
   endtask

   task automatic push_mem(input logic we, input logic [5:0] addr, input logic [31:0] wd);
      exp_mem_q.push_back({we, addr, wd});
   endtask

   // Called #1 after a rising edge; returns #1 after the completing edge.
   task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                             input logic [7:0] wdata);
      bit done = 0;
      bus.READ      = rd;
      bus.WRITE     = wr;
      bus.ADDRESS   = addr;
      bus.WRITEDATA = wdata;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!bus.BUSYWAIT) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL access_timeout addr=%0h", addr);
      end
      @(posedge CLK);
      #1;
      bus.READ  = 1'b0;
      bus.WRITE = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit done;
      for (int b = 0; b < 64; b++)
         mem[b] = {8'(b * 4 + 3), 8'(b * 4 + 2), 8'(b * 4 + 1), 8'(b * 4)};
      mem[6'h0B] = 32'hDDCCBBAA;
      bus.READ      = 1'b0;
      bus.WRITE     = 1'b0;
      bus.ADDRESS   = 8'h00;
      bus.WRITEDATA = 8'h00;
      stall_cnt     = 0;
      RESET         = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_busywait", {63'd0, bus.BUSYWAIT}, 64'd0);
      check("reset_mem_read", {63'd0, bus.MEM_READ}, 64'd0);
      check("reset_mem_write", {63'd0, bus.MEM_WRITE}, 64'd0);
      check("reset_readdata", {56'd0, bus.READDATA}, 64'd0);
      check("reset_state", {62'd0, dbg_state}, 64'd0);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      check("idle_no_request_busywait", {63'd0, bus.BUSYWAIT}, 64'd0);

      // 1: clean miss after reset
      push_mem(1'b0, 6'h0B, 32'h0);
      push_cpu(1'b1, 8'hAA, 8'd7);
      cpu_access(1'b1, 1'b0, 8'h2C, 8'h00);

      // 2: read hit in same line
      push_cpu(1'b1, 8'hDD, 8'd0);
      cpu_access(1'b1, 1'b0, 8'h2F, 8'h00);

      // 3: write hit, then dirty eviction by tag 3
      push_cpu(1'b0, 8'h00, 8'd0);
      cpu_access(1'b0, 1'b1, 8'h2D, 8'h55);
      push_mem(1'b1, 6'h0B, 32'hDDCC55AA);
      push_mem(1'b0, 6'h1B, 32'h0);
      push_cpu(1'b1, 8'h6C, 8'd12);
      cpu_access(1'b1, 1'b0, 8'h6C, 8'h00);
      push_mem(1'b0, 6'h0B, 32'h0);
      push_cpu(1'b1, 8'h55, 8'd7);
      cpu_access(1'b1, 1'b0, 8'h2D, 8'h00);

      // 4: write on clean miss, then its dirty line is written back
      push_mem(1'b0, 6'h00, 32'h0);
      push_cpu(1'b0, 8'h00, 8'd7);
      cpu_access(1'b0, 1'b1, 8'h00, 8'h77);
      push_mem(1'b1, 6'h00, 32'h03020177);
      push_mem(1'b0, 6'h08, 32'h0);
      push_cpu(1'b1, 8'h20, 8'd12);
      cpu_access(1'b1, 1'b0, 8'h20, 8'h00);

      // 6: READ and WRITE together behave as a write hit
      push_cpu(1'b0, 8'h00, 8'd0);
      cpu_access(1'b1, 1'b1, 8'h2C, 8'h11);
      push_mem(1'b1, 6'h0B, 32'hDDCC5511);
      push_mem(1'b0, 6'h1B, 32'h0);
      push_cpu(1'b1, 8'h6C, 8'd12);
      cpu_access(1'b1, 1'b0, 8'h6C, 8'h00);

      // 5: reset during the third fetch cycle, then the held read refetches
      bus.READ    = 1'b1;
      bus.WRITE   = 1'b0;
      bus.ADDRESS = 8'h90;
      @(posedge CLK);
      #1;
      check("fetch_started_mem_read", {63'd0, bus.MEM_READ}, 64'd1);
      check("fetch_address", {58'd0, bus.MEM_ADDRESS}, 64'h24);
      repeat (2) @(posedge CLK);
      #2;
      RESET = 1'b0;
      #1;
      check("abort_mem_read", {63'd0, bus.MEM_READ}, 64'd0);
      check("abort_busywait", {63'd0, bus.BUSYWAIT}, 64'd0);
      check("abort_state", {62'd0, dbg_state}, 64'd0);
      repeat (2) @(posedge CLK);
      #1;
      push_mem(1'b0, 6'h24, 32'h0);
      push_cpu(1'b1, 8'h90, 8'd7);
      RESET = 1'b1;
      done  = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!bus.BUSYWAIT) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL refetch_timeout addr=90");
      end
      @(posedge CLK);
      #1;
      bus.READ = 1'b0;

      // Contents cleared by reset: previously cached line misses again
      push_mem(1'b0, 6'h0B, 32'h0);
      push_cpu(1'b1, 8'h11, 8'd7);
      cpu_access(1'b1, 1'b0, 8'h2C, 8'h00);

      repeat (3) @(posedge CLK);
      #1;
      check("cpu_queue_drained", 64'(exp_q.size()), 64'd0);
      check("mem_queue_drained", 64'(exp_mem_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back data cache controller between the CPU's load/store path (ALURESULT as address, REGOUT1 as store data) and the shared block-wide data memory.
- Serves hits within the same cycle.
- On a miss, stalls the CPU via BUSYWAIT and runs an FSM that writes back a dirty victim and fetches the new 4-byte block.

Parameters:
None. Geometry is fixed:
- 8 lines × 4 bytes.
- 8-bit byte address split as tag[7:5], index[4:2], offset[1:0].

Ports:
CLK  input  1  system clock, rising-edge active
RESET  input  1  asynchronous, active-low reset (0 = reset)
READ  input  1  CPU load request, held until BUSYWAIT=0
WRITE  input  1  CPU store request, held until BUSYWAIT=0
ADDRESS  input  8  CPU byte address
WRITEDATA  input  8  CPU store byte
READDATA  output  8  load byte, combinational from the indexed line
BUSYWAIT  output  1  CPU stall, combinational
MEM_READ  output  1  block fetch request
MEM_WRITE  output  1  block write-back request
MEM_ADDRESS  output  6  block address {tag,index}
MEM_WRITEDATA  output  32  victim block, byte0 in [7:0]
MEM_READDATA  input  32  fetched block, byte0 in [7:0]
MEM_BUSYWAIT  input  1  memory busy; memory holds it high while servicing and drops it for one cycle when the transfer completes

Behaviour:

Storage and hit logic:
- Storage per line: valid, dirty, tag[2:0], data[31:0].
- hit = valid[index] & (tag[index]==ADDRESS[7:5]).

States: IDLE, WRITEBACK, FETCH, UPDATE.

IDLE:
- BUSYWAIT = (READ|WRITE) & ~hit.
- READDATA = data[index] byte selected by offset. It is driven whenever in IDLE, and is don't-care on a miss.
- Write hit: on the rising edge, the byte at offset is written and dirty[index] is set to 1. Zero added latency.
- Read hit: zero added latency; the CPU samples READDATA on the same edge.
- Miss with dirty[index]=1: next state WRITEBACK.
- Miss with dirty[index]=0: next state FETCH.

WRITEBACK:
- MEM_WRITE=1, MEM_ADDRESS={tag[index],index}, MEM_WRITEDATA=data[index], BUSYWAIT=1.
- Leaves to FETCH on the first edge with MEM_BUSYWAIT=0.

FETCH:
- MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5],index}, BUSYWAIT=1.
- On the first edge with MEM_BUSYWAIT=0: latches MEM_READDATA into a fill register and goes to UPDATE.

UPDATE (one cycle):
- BUSYWAIT=1.
- On the edge: data[index]=fill, tag[index]=ADDRESS[7:5], valid=1, dirty=0; next state IDLE.
- The access then completes as a hit in IDLE. Miss latency is therefore memory latency + 2 cycles (clean) or 2×memory latency + 2 cycles (dirty).

Request and output rules:
- MEM_READ and MEM_WRITE are never high together, and both are 0 in IDLE and UPDATE.
- MEM_ADDRESS and MEM_WRITEDATA are 0 when not requesting.
- READ and WRITE both high is treated as WRITE; READDATA is still driven.
- ADDRESS, READ and WRITE must stay stable while BUSYWAIT=1. The controller does not re-latch them.
- Neither READ nor WRITE: no state change, BUSYWAIT=0.

Reset (RESET=0, asynchronous):
- State=IDLE, all valid=0, all dirty=0.
- Tags/data are not required to clear.
- All outputs go to 0 immediately.
- Reset mid-WRITEBACK or mid-FETCH aborts the transfer: MEM_READ/MEM_WRITE drop at once and no line is updated.
- First cycle after release: every access misses.

Test Plan:
1. Reset, then READ at 0x2C with memory block 0x0B = 0xDDCCBBAA, 5-cycle memory latency -> BUSYWAIT high for 7 cycles, MEM_READ with MEM_ADDRESS=0x0B, then READDATA=0xAA (offset 0) while BUSYWAIT=0.
2. Follow with READ at 0x2F -> BUSYWAIT stays 0, READDATA=0xDD, no MEM_READ.
3. WRITE 0x55 to 0x2D (hit), then READ 0x6C (same index 3, tag 3) -> MEM_WRITE with MEM_ADDRESS=0x0B and MEM_WRITEDATA=0xDDCC55AA, then MEM_READ with MEM_ADDRESS=0x1B, then line refilled with dirty=0.
4. WRITE 0x77 to 0x00 on a clean miss -> no MEM_WRITE, fetch of block 0x00, byte 0 becomes 0x77 on the IDLE edge after UPDATE, dirty[0]=1.
5. RESET low during FETCH (cycle 3 of 5) -> MEM_READ and BUSYWAIT drop asynchronously; after release, READ of the same address misses again and refetches.
6. READ and WRITE both high at hit address 0x2C with WRITEDATA=0x11 -> byte written, dirty set, no stall.
